// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: drives the pipeline register
// stall/flush controls and the execute forwarding muxes, plus a data-memory watchdog.
module pipe_hazard_ctrl #(
  parameter int RESET_FLUSH_CYCLES = 4,
  parameter int DMEM_TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [1:0]  rs_used_d,
  input  logic [4:0]  rs1_e,
  input  logic [4:0]  rs2_e,
  input  logic [4:0]  wa_e,
  input  logic        regfile_we_e,
  input  logic        load_e,
  input  logic [4:0]  wa_m,
  input  logic        regfile_we_m,
  input  logic [4:0]  wa_w,
  input  logic        regfile_we_w,
  input  logic        redirect_e,
  input  logic        dmem_req_m,
  input  logic        dmem_ready,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_m,
  output logic        flush_w,
  output logic [1:0]  fwd_a_e,
  output logic [1:0]  fwd_b_e,
  output logic        dmem_timeout,
  output logic [31:0] stall_count
);

  localparam int FC_W = (RESET_FLUSH_CYCLES > 1) ? $clog2(RESET_FLUSH_CYCLES) : 1;
  localparam int WC_W = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [FC_W-1:0] FLUSH_INIT = FC_W'(RESET_FLUSH_CYCLES - 1);
  localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(DMEM_TIMEOUT - 1);

  typedef enum logic [1:0] {RSTFLUSH, RUN, MEM_WAIT, FAULT} state_t;

  state_t          state;
  logic [FC_W-1:0] flush_cnt;
  logic [WC_W-1:0] wait_cnt;
  logic            mw;
  logic            load_use;

  assign mw = dmem_req_m & ~dmem_ready;
  assign load_use = load_e & regfile_we_e & (wa_e != 5'd0) &
                    ((rs_used_d[0] & (wa_e == rs1_d)) | (rs_used_d[1] & (wa_e == rs2_d)));

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    flush_w = 1'b0;
    case (state)
      RSTFLUSH: begin
        stall_f = 1'b1;
        flush_d = 1'b1;
        flush_e = 1'b1;
        flush_m = 1'b1;
        flush_w = 1'b1;
      end
      RUN: begin
        if (mw) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = 1'b1;
          flush_w = 1'b1;
        end else if (redirect_e) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = 1'b1;
          flush_w = 1'b1;
        end
      end
      FAULT: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
      end
      default: ;
    endcase
  end

  // M has priority over W because it holds the younger result; x0 is never forwarded
  always_comb begin
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    if (regfile_we_m && wa_m != 5'd0 && wa_m == rs1_e)      fwd_a_e = 2'b10;
    else if (regfile_we_w && wa_w != 5'd0 && wa_w == rs1_e) fwd_a_e = 2'b01;
    if (regfile_we_m && wa_m != 5'd0 && wa_m == rs2_e)      fwd_b_e = 2'b10;
    else if (regfile_we_w && wa_w != 5'd0 && wa_w == rs2_e) fwd_b_e = 2'b01;
  end

  assign dmem_timeout = (state == FAULT);

  // wait_cnt counts consecutive unready cycles including the first one seen in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RSTFLUSH;
      flush_cnt   <= FLUSH_INIT;
      wait_cnt    <= '0;
      stall_count <= '0;
    end else begin
      if ((state == RUN || state == MEM_WAIT) && stall_f && stall_count != 32'hFFFF_FFFF)
        stall_count <= stall_count + 32'd1;
      case (state)
        RSTFLUSH: begin
          if (flush_cnt == '0) state <= RUN;
          else                 flush_cnt <= flush_cnt - FC_W'(1);
        end
        RUN: begin
          if (mw) begin
            if (DMEM_TIMEOUT == 1) begin
              state <= FAULT;
            end else begin
              state    <= MEM_WAIT;
              wait_cnt <= WC_W'(1);
            end
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= FAULT;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each cycle's stimulus pushes its expected
// outputs, which are popped and compared mid-cycle.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [1:0] rs_used_d;
    logic [4:0] rs1_e;
    logic [4:0] rs2_e;
    logic [4:0] wa_e;
    logic       regfile_we_e;
    logic       load_e;
    logic [4:0] wa_m;
    logic       regfile_we_m;
    logic [4:0] wa_w;
    logic       regfile_we_w;
    logic       redirect_e;
    logic       dmem_req_m;
    logic       dmem_ready;
  } stim_t;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        timeout;
    logic [31:0] count;
  } exp_t;

  // ctrl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w}
  localparam logic [7:0] C_FLUSH = 8'b1000_1111;
  localparam logic [7:0] C_NONE  = 8'b0000_0000;
  localparam logic [7:0] C_LU    = 8'b1100_0100;
  localparam logic [7:0] C_RD    = 8'b0000_1100;
  localparam logic [7:0] C_MW    = 8'b1111_0001;
  localparam logic [7:0] C_FLT   = 8'b1111_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, wa_e, wa_m, wa_w;
  logic [1:0]  rs_used_d;
  logic        regfile_we_e, load_e, regfile_we_m, regfile_we_w;
  logic        redirect_e, dmem_req_m, dmem_ready;
  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e, flush_m, flush_w;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic        dmem_timeout;
  logic [31:0] stall_count;

  exp_t exp_q[$];
  int   check_count = 0;
  int   error_count = 0;
  int   step = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RESET_FLUSH_CYCLES(4), .DMEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs_used_d(rs_used_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e),
    .wa_e(wa_e), .regfile_we_e(regfile_we_e), .load_e(load_e),
    .wa_m(wa_m), .regfile_we_m(regfile_we_m),
    .wa_w(wa_w), .regfile_we_w(regfile_we_w),
    .redirect_e(redirect_e), .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .dmem_timeout(dmem_timeout), .stall_count(stall_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s step %0d: got 0x%0h, expected 0x%0h", tag, step, observed, expected);
    end
  endtask

  task automatic scoreboardCheck();
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      checkOutput("ctrl", {24'd0, stall_f, stall_d, stall_e, stall_m,
                           flush_d, flush_e, flush_m, flush_w}, {24'd0, e.ctrl});
      checkOutput("fwd_a", {30'd0, fwd_a_e}, {30'd0, e.fwd_a});
      checkOutput("fwd_b", {30'd0, fwd_b_e}, {30'd0, e.fwd_b});
      checkOutput("timeout", {31'd0, dmem_timeout}, {31'd0, e.timeout});
      checkOutput("stall_count", stall_count, e.count);
    end
  endtask

  // One cycle: drive just after the rising edge, compare on the falling edge
  task automatic applyStimulus(input stim_t s, input exp_t e);
    rst_n        = s.rst_n;
    rs1_d        = s.rs1_d;
    rs2_d        = s.rs2_d;
    rs_used_d    = s.rs_used_d;
    rs1_e        = s.rs1_e;
    rs2_e        = s.rs2_e;
    wa_e         = s.wa_e;
    regfile_we_e = s.regfile_we_e;
    load_e       = s.load_e;
    wa_m         = s.wa_m;
    regfile_we_m = s.regfile_we_m;
    wa_w         = s.wa_w;
    regfile_we_w = s.regfile_we_w;
    redirect_e   = s.redirect_e;
    dmem_req_m   = s.dmem_req_m;
    dmem_ready   = s.dmem_ready;
    exp_q.push_back(e);
    @(negedge clk);
    scoreboardCheck();
    step++;
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic exp_t ex(input logic [7:0] c, input logic [1:0] fa, input logic [1:0] fb,
                              input logic to, input logic [31:0] cnt);
    exp_t e;
    e.ctrl = c;
    e.fwd_a = fa;
    e.fwd_b = fb;
    e.timeout = to;
    e.count = cnt;
    return e;
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;

    // Reset held, then exactly four scrub cycles before RUN
    s = idle(); s.rst_n = 1'b0;
    applyStimulus(s, ex(C_FLUSH, 2'b00, 2'b00, 1'b0, 32'd0));
    s = idle();
    repeat (4) applyStimulus(s, ex(C_FLUSH, 2'b00, 2'b00, 1'b0, 32'd0));
    applyStimulus(idle(), ex(C_NONE, 2'b00, 2'b00, 1'b0, 32'd0));

    // Load-use on rs1, then the same with x0 as destination
    s = idle(); s.load_e = 1; s.regfile_we_e = 1; s.wa_e = 5; s.rs1_d = 5; s.rs_used_d = 2'b01;
    applyStimulus(s, ex(C_LU, 2'b00, 2'b00, 1'b0, 32'd0));
    applyStimulus(idle(), ex(C_NONE, 2'b00, 2'b00, 1'b0, 32'd1));
    s.wa_e = 0; s.rs1_d = 0;
    applyStimulus(s, ex(C_NONE, 2'b00, 2'b00, 1'b0, 32'd1));

    // Load-use on rs2, then a matching register that is not read
    s = idle(); s.load_e = 1; s.regfile_we_e = 1; s.wa_e = 9; s.rs2_d = 9; s.rs_used_d = 2'b10;
    applyStimulus(s, ex(C_LU, 2'b00, 2'b00, 1'b0, 32'd1));
    applyStimulus(idle(), ex(C_NONE, 2'b00, 2'b00, 1'b0, 32'd2));
    s.rs_used_d = 2'b01;
    applyStimulus(s, ex(C_NONE, 2'b00, 2'b00, 1'b0, 32'd2));

    // Redirect wins over load-use
    s = idle(); s.load_e = 1; s.regfile_we_e = 1; s.wa_e = 5; s.rs1_d = 5; s.rs_used_d = 2'b01;
    s.redirect_e = 1;
    applyStimulus(s, ex(C_RD, 2'b00, 2'b00, 1'b0, 32'd2));
    applyStimulus(idle(), ex(C_NONE, 2'b00, 2'b00, 1'b0, 32'd2));

    // Four-cycle memory access: three stall cycles
    s = idle(); s.dmem_req_m = 1;
    applyStimulus(s, ex(C_MW, 2'b00, 2'b00, 1'b0, 32'd2));
    applyStimulus(s, ex(C_MW, 2'b00, 2'b00, 1'b0, 32'd3));
    applyStimulus(s, ex(C_MW, 2'b00, 2'b00, 1'b0, 32'd4));
    s.dmem_ready = 1;
    applyStimulus(s, ex(C_NONE, 2'b00, 2'b00, 1'b0, 32'd5));
    applyStimulus(idle(), ex(C_NONE, 2'b00, 2'b00, 1'b0, 32'd5));

    // Single-cycle access: no stall and no transition
    applyStimulus(s, ex(C_NONE, 2'b00, 2'b00, 1'b0, 32'd5));
    applyStimulus(idle(), ex(C_NONE, 2'b00, 2'b00, 1'b0, 32'd5));

    // Redirect is held back while memory is waiting, then honoured in RUN
    s = idle(); s.dmem_req_m = 1; s.redirect_e = 1;
    applyStimulus(s, ex(C_MW, 2'b00, 2'b00, 1'b0, 32'd5));
    applyStimulus(s, ex(C_MW, 2'b00, 2'b00, 1'b0, 32'd6));
    s.dmem_ready = 1;
    applyStimulus(s, ex(C_NONE, 2'b00, 2'b00, 1'b0, 32'd7));
    s = idle(); s.redirect_e = 1;
    applyStimulus(s, ex(C_RD, 2'b00, 2'b00, 1'b0, 32'd7));
    applyStimulus(idle(), ex(C_NONE, 2'b00, 2'b00, 1'b0, 32'd7));

    // Forwarding priority and x0 suppression
    s = idle(); s.wa_m = 7; s.wa_w = 7; s.rs1_e = 7; s.regfile_we_m = 1; s.regfile_we_w = 1;
    applyStimulus(s, ex(C_NONE, 2'b10, 2'b00, 1'b0, 32'd7));
    s.regfile_we_m = 0;
    applyStimulus(s, ex(C_NONE, 2'b01, 2'b00, 1'b0, 32'd7));
    s.regfile_we_m = 1; s.rs1_e = 0;
    applyStimulus(s, ex(C_NONE, 2'b00, 2'b00, 1'b0, 32'd7));
    s.wa_m = 0; s.wa_w = 0;
    applyStimulus(s, ex(C_NONE, 2'b00, 2'b00, 1'b0, 32'd7));
    s.rs1_e = 7; s.rs2_e = 3; s.wa_m = 3; s.wa_w = 7;
    applyStimulus(s, ex(C_NONE, 2'b01, 2'b10, 1'b0, 32'd7));

    // Memory never responds: FAULT after four unready cycles, held until reset
    s = idle(); s.dmem_req_m = 1;
    applyStimulus(s, ex(C_MW, 2'b00, 2'b00, 1'b0, 32'd7));
    applyStimulus(s, ex(C_MW, 2'b00, 2'b00, 1'b0, 32'd8));
    applyStimulus(s, ex(C_MW, 2'b00, 2'b00, 1'b0, 32'd9));
    applyStimulus(s, ex(C_MW, 2'b00, 2'b00, 1'b0, 32'd10));
    applyStimulus(s, ex(C_FLT, 2'b00, 2'b00, 1'b1, 32'd11));
    s.dmem_ready = 1; s.redirect_e = 1;
    applyStimulus(s, ex(C_FLT, 2'b00, 2'b00, 1'b1, 32'd11));
    s = idle(); s.rst_n = 1'b0;
    applyStimulus(s, ex(C_FLUSH, 2'b00, 2'b00, 1'b0, 32'd0));
    s = idle();
    repeat (4) applyStimulus(s, ex(C_FLUSH, 2'b00, 2'b00, 1'b0, 32'd0));
    applyStimulus(idle(), ex(C_NONE, 2'b00, 2'b00, 1'b0, 32'd0));

    // Reset arriving mid memory wait
    s = idle(); s.dmem_req_m = 1;
    applyStimulus(s, ex(C_MW, 2'b00, 2'b00, 1'b0, 32'd0));
    applyStimulus(s, ex(C_MW, 2'b00, 2'b00, 1'b0, 32'd1));
    s.rst_n = 1'b0;
    applyStimulus(s, ex(C_FLUSH, 2'b00, 2'b00, 1'b0, 32'd0));
    s = idle();
    repeat (4) applyStimulus(s, ex(C_FLUSH, 2'b00, 2'b00, 1'b0, 32'd0));
    applyStimulus(idle(), ex(C_NONE, 2'b00, 2'b00, 1'b0, 32'd0));

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard and sequencing controller for the 5-stage RISC-V core. It drives the stall and flush inputs of the four inter-stage pipeline registers (F/D, D/E, E/M, M/W) and the execute-stage forwarding muxes. It resolves load-use hazards, control redirects and multi-cycle data-memory accesses, and performs a post-reset pipeline scrub. A watchdog latches a fault if data memory never responds.

## Interface
- `RESET_FLUSH_CYCLES`, default 4: cycles of full-pipeline flush after reset release; must be ≥1.
- `DMEM_TIMEOUT`, default 255: consecutive unready data-memory cycles before the block enters FAULT; must be ≥1.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rs1_d`, `rs2_d`  in  5 each  decode-stage source registers.
- `rs_used_d`  in  2  bit0: `rs1_d` is read; bit1: `rs2_d` is read.
- `rs1_e`, `rs2_e`  in  5 each  execute-stage source registers.
- `wa_e`, `regfile_we_e`, `load_e`  in  5/1/1  execute-stage destination, write enable, and load flag.
- `wa_m`, `regfile_we_m`  in  5/1  memory-stage destination and write enable.
- `wa_w`, `regfile_we_w`  in  5/1  writeback-stage destination and write enable.
- `redirect_e`  in  1  taken branch or jump resolved in execute.
- `dmem_req_m`  in  1  memory stage holds a valid load or store.
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `stall_f`, `stall_d`, `stall_e`, `stall_m`  out  1 each  hold PC, F/D, D/E and E/M respectively.
- `flush_d`, `flush_e`, `flush_m`, `flush_w`  out  1 each  insert a bubble into F/D, D/E, E/M and M/W respectively.
- `fwd_a_e`, `fwd_b_e`  out  2 each  operand source: 00 = regfile, 01 = W result, 10 = M result.
- `dmem_timeout`  out  1  sticky fault flag.
- `stall_count`  out  32  saturating count of stalled cycles.

## Operation

States: RSTFLUSH, RUN, MEM_WAIT, FAULT.

**Reset**
- While `rst_n` is low, the state is RSTFLUSH, `flush_cnt = RESET_FLUSH_CYCLES-1`, `wait_cnt = 0`, `stall_count = 0` and `dmem_timeout = 0`.

**RSTFLUSH**
- Outputs: all four `flush_*` = 1, `stall_f` = 1, other stalls 0.
- `flush_cnt` decrements each cycle. When it is 0, the next state is RUN.

**RUN**
- Signals are evaluated in priority order; outputs are combinational from state and inputs.
- Memory wait: `mw = dmem_req_m & ~dmem_ready`.
  - Outputs: `stall_f`, `stall_d`, `stall_e`, `stall_m` = 1 and `flush_w` = 1.
  - Next state is MEM_WAIT. `wait_cnt` becomes 1.
- Redirect: `redirect_e` with no `mw`.
  - Outputs: `flush_d` = 1, `flush_e` = 1.
- Load-use: `load_e & regfile_we_e & (wa_e != 0)`, and `wa_e` matches `rs1_d` with `rs_used_d[0]` or `rs2_d` with `rs_used_d[1]`. Applies only with no `mw` and no redirect.
  - Outputs: `stall_f` = 1, `stall_d` = 1, `flush_e` = 1.
- All other stall and flush outputs are 0.

**MEM_WAIT**
- If `dmem_ready`: stalls and `flush_w` drop in this same cycle, the pipeline advances, and the next state is RUN.
- Otherwise the outputs are the same as for `mw`, and `wait_cnt` increments.
- `redirect_e` and load-use are ignored here. The execute stage is frozen, so they are re-evaluated in RUN.
- FAULT condition: `mw` is true for `DMEM_TIMEOUT` consecutive cycles, counting the first cycle in RUN. The next state is then FAULT.

**FAULT**
- Outputs: all four stalls = 1, all flushes = 0, `dmem_timeout` = 1.
- Exits only through `rst_n`.

**Forwarding** (combinational, all states)
- `fwd_a_e` = 10 if `regfile_we_m & (wa_m != 0) & (wa_m == rs1_e)`.
- Else 01 if the same condition holds with W (`regfile_we_w`, `wa_w`).
- Else 00.
- M has priority over W. x0 is never forwarded. `fwd_b_e` is identical, using `rs2_e`.

**stall_count**
- Increments on every cycle in RUN or MEM_WAIT with `stall_f` = 1.
- Saturates at 0xFFFF_FFFF.
- Never counts in RSTFLUSH or FAULT.

## Timing
- Stall, flush and forwarding outputs are combinational with zero latency. The pipeline registers sample them at their own clock edge.
- RSTFLUSH lasts exactly `RESET_FLUSH_CYCLES` cycles after `rst_n` rises. RUN begins on the next cycle.
- Load-use costs exactly 1 stall cycle: the next cycle re-evaluates with the load in M, so no repeat stall occurs.
- A memory access taking N cycles (`dmem_ready` high on cycle N) produces N-1 stall cycles.
- `dmem_ready` arriving in the first `mw` cycle means no stall and no transition.
- `rst_n` asserted mid-MEM_WAIT or in FAULT returns the block to RSTFLUSH asynchronously. `dmem_timeout` clears.
- The `wait_cnt` width is sized for `DMEM_TIMEOUT`. It resets to 0 on every exit from MEM_WAIT.

## Test plan
- Reset release, `RESET_FLUSH_CYCLES` = 4 → flushes and `stall_f` high for exactly 4 cycles, then all outputs 0 in RUN; `stall_count` = 0.
- Load to x5 in E, `rs1_d` = 5, `rs_used_d` = 01 → one cycle of `stall_f`/`stall_d`/`flush_e`; `stall_count` = 1. Repeat with `wa_e` = 0 → no stall.
- `redirect_e` and load-use together → only `flush_d`/`flush_e`, no stall.
- `dmem_req_m` held with `dmem_ready` low for 3 cycles, then high → `stall_f`/`stall_d`/`stall_e`/`stall_m` and `flush_w` high for 3 cycles, low on the 4th; `stall_count` += 3.
- `DMEM_TIMEOUT` = 4, `dmem_ready` never high → FAULT after 4 cycles, `dmem_timeout` = 1, all stalls held; asserting `rst_n` low clears it.
- `wa_m` = `wa_w` = `rs1_e` = 7, both write enables high → `fwd_a_e` = 10. With `regfile_we_m` = 0 → 01. With `rs1_e` = 0 → 00.
